// File: rtl/onewire_master_bit.sv
// 1-Wire master bit engine: one write0, write1/read or reset/presence slot per request.
// Define ONEWIRE_MASTER_SHORT_EN to abort on a shorted bus at acceptance (rsp_err).
module onewire_master_bit #(
   parameter int CDR_N = 75,
   parameter int CDR_O = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_cmd,
   input  logic       req_ovd,
   output logic       rsp_valid,
   output logic       rsp_data,
   output logic       rsp_err,
   output logic       owr_e,
   input  logic       owr_i
);

   typedef enum logic [1:0] {IDLE, DRIVE, RELEASE, DONE} state_t;

   localparam logic [9:0] DIV_N_M1 = 10'(CDR_N - 1);
   localparam logic [9:0] DIV_O_M1 = 10'(CDR_O - 1);

   state_t     state_q, state_d;
   logic       ready_q, ready_d;
   logic       owr_e_q, owr_e_d;
   logic [1:0] cmd_q, cmd_d;
   logic       ovd_q, ovd_d;
   logic [9:0] presc_q, presc_d;
   logic [7:0] t_q, t_d;
   logic       smp_q, smp_d;
   logic       data_q, data_d;
   logic       short_q, short_d;
   logic       err_q, err_d;

   logic       accept;
   logic       tick;
   logic [7:0] t_inc;
   logic       is_rst;
   logic [7:0] drive_ticks;
   logic [7:0] sample_tick;
   logic [7:0] done_tick;

   // Slot timing in ticks; command 11 behaves as a reset slot.
   always_comb begin
      accept      = req_valid && ready_q;
      tick        = (presc_q == (ovd_q ? DIV_O_M1 : DIV_N_M1));
      t_inc       = t_q + 8'd1;
      is_rst      = cmd_q[1];
      drive_ticks = is_rst ? 8'd64 : ((cmd_q == 2'b00) ? 8'd8 : 8'd1);
      sample_tick = is_rst ? 8'd73 : 8'd2;
      done_tick   = is_rst ? 8'd128 : 8'd9;
   end

   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      owr_e_d = owr_e_q;
      cmd_d   = cmd_q;
      ovd_d   = ovd_q;
      presc_d = presc_q;
      t_d     = t_q;
      smp_d   = smp_q;
      data_d  = data_q;
      short_d = short_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (accept) begin
               cmd_d   = req_cmd;
               ovd_d   = req_ovd;
               presc_d = '0;
               t_d     = '0;
               ready_d = 1'b0;
               state_d = DRIVE;
               owr_e_d = 1'b1;
               short_d = 1'b0;
`ifdef ONEWIRE_MASTER_SHORT_EN
               if (!owr_i) begin
                  state_d = RELEASE;
                  owr_e_d = 1'b0;
                  short_d = 1'b1;
               end
`endif
            end
         end
         DRIVE, RELEASE: begin
            if (tick) begin
               presc_d = '0;
               t_d     = t_inc;
               if (state_q == DRIVE && t_inc == drive_ticks) begin
                  state_d = RELEASE;
                  owr_e_d = 1'b0;
               end
               // Presence is an active-low pulse from the slave, so invert it.
               if (t_inc == sample_tick) begin
                  smp_d = is_rst ? ~owr_i : owr_i;
               end
               if (t_inc == done_tick) begin
                  state_d = DONE;
                  owr_e_d = 1'b0;
                  data_d  = smp_q;
                  err_d   = 1'b0;
               end
`ifdef ONEWIRE_MASTER_SHORT_EN
               if (short_q && t_inc == 8'd1) begin
                  state_d = DONE;
                  data_d  = 1'b0;
                  err_d   = 1'b1;
               end
`endif
            end else begin
               presc_d = presc_q + 10'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
            presc_d = '0;
            t_d     = '0;
         end
         default: begin
            state_d = IDLE;
            owr_e_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         owr_e_q <= 1'b0;
         cmd_q   <= '0;
         ovd_q   <= 1'b0;
         presc_q <= '0;
         t_q     <= '0;
         smp_q   <= 1'b0;
         data_q  <= 1'b0;
         short_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         owr_e_q <= owr_e_d;
         cmd_q   <= cmd_d;
         ovd_q   <= ovd_d;
         presc_q <= presc_d;
         t_q     <= t_d;
         smp_q   <= smp_d;
         data_q  <= data_d;
         short_q <= short_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = data_q;
   assign owr_e     = owr_e_q;
`ifdef ONEWIRE_MASTER_SHORT_EN
   assign rsp_err   = err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule
